// File: rtl/ultrasonic_pkg.sv
// Shared types and constants for the multi-channel ultrasonic ranger.
package ultrasonic_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StTrig,
    StWaitRise,
    StMeasure,
    StGap
  } ranger_state_e;

  // Round-trip sound travel time for one centimetre of range.
  localparam int unsigned US_PER_CM = 58;

  // Clock cycles per microsecond tick; never below one.
  function automatic int unsigned tick_div(input int unsigned clk_hz);
    int unsigned d;
    d = clk_hz / 1_000_000;
    return (d == 0) ? 1 : d;
  endfunction

endpackage

// File: rtl/us_echo_sync.sv
// Per-channel two-flop synchroniser for the asynchronous echo pins, plus single-cycle
// rise/fall pulses derived from the synchronised level.
module us_echo_sync #(
  parameter int unsigned N_CH = 4
) (
  input  logic            clk,
  input  logic            reset_p,
  input  logic [N_CH-1:0] echo,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic meta_q, sync_q, prev_q;

    always_ff @(posedge clk) begin
      if (reset_p) begin
        meta_q <= 1'b0;
        sync_q <= 1'b0;
        prev_q <= 1'b0;
      end else begin
        meta_q <= echo[i];
        sync_q <= meta_q;
        prev_q <= sync_q;
      end
    end

    assign rise[i] = sync_q & ~prev_q;
    assign fall[i] = ~sync_q & prev_q;
  end

endmodule

// File: rtl/ultrasonic_multi_ranger.sv
// Round-robin N-channel HC-SR04 ranging controller: triggers one sensor at a time, times the echo
// in centimetres, and keeps an IIR-filtered distance, sticky timeout and near flag per channel.
module ultrasonic_multi_ranger
  import ultrasonic_pkg::*;
#(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned TRIG_US    = 10,
  parameter int unsigned TIMEOUT_US = 25_000,
  parameter int unsigned GAP_US     = 60_000,
  parameter int unsigned DIST_W     = 9,
  parameter int unsigned AVG_SHIFT  = 2,
  parameter int unsigned NEAR_CM    = 20,
  localparam int unsigned CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                   clk,
  input  logic                   reset_p,
  input  logic [N_CH-1:0]        en_mask,
  input  logic [N_CH-1:0]        echo,
  output logic [N_CH-1:0]        trig,
  output logic [N_CH*DIST_W-1:0] dist_flat,
  output logic [DIST_W-1:0]      raw_dist,
  output logic                   meas_valid,
  output logic [CH_W-1:0]        meas_ch,
  output logic [N_CH-1:0]        timeout,
  output logic [N_CH-1:0]        near
);

  localparam int unsigned       TickDiv = tick_div(CLK_HZ);
  localparam int unsigned       SumW    = CH_W + 1;
  localparam logic [5:0]        SubLast = 6'(US_PER_CM - 1);
  localparam logic [DIST_W-1:0] DistMax = '1;
  localparam logic [DIST_W-1:0] DistOne = DIST_W'(1);
  localparam logic [DIST_W-1:0] NearCm  = DIST_W'(NEAR_CM);
  localparam logic [CH_W-1:0]   LastCh  = CH_W'(N_CH - 1);
  localparam logic [SumW-1:0]   NumCh   = SumW'(N_CH);

  ranger_state_e state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d, ptr_q, ptr_d, next_ch;
  logic [31:0]       pre_q, us_q, us_d, tmo_q, tmo_d;
  logic [5:0]        sub_q, sub_d, sub_n;
  logic [DIST_W-1:0] cm_q, cm_d, cm_n;
  logic              tick, tmo_exp, done, done_to;
  logic [DIST_W-1:0] result_cm, cur_avg, avg_new;
  logic signed [DIST_W:0] diff;
  logic [N_CH-1:0]   rise, fall;

  logic [N_CH-1:0][DIST_W-1:0] avg_q;
  logic [N_CH-1:0]   first_q, timeout_q, near_q;
  logic [DIST_W-1:0] raw_q;
  logic              meas_valid_q;
  logic [CH_W-1:0]   meas_ch_q;

  us_echo_sync #(
    .N_CH(N_CH)
  ) u_sync (
    .clk    (clk),
    .reset_p(reset_p),
    .echo   (echo),
    .rise   (rise),
    .fall   (fall)
  );

  assign tick    = (pre_q == TickDiv - 1);
  assign tmo_exp = tick && (tmo_q == TIMEOUT_US - 1);

  always_ff @(posedge clk) begin
    if (reset_p) pre_q <= '0;
    else         pre_q <= tick ? '0 : pre_q + 32'd1;
  end

  // First enabled channel at or after the pointer, wrapping; the lowest offset wins.
  always_comb begin
    logic [SumW-1:0] sum;
    logic [CH_W-1:0] idx;
    next_ch = ptr_q;
    sum     = '0;
    idx     = '0;
    for (int i = int'(N_CH) - 1; i >= 0; i--) begin
      sum = {1'b0, ptr_q} + SumW'(i);
      idx = (sum >= NumCh) ? CH_W'(sum - NumCh) : CH_W'(sum);
      if (en_mask[idx]) next_ch = idx;
    end
  end

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    ptr_d     = ptr_q;
    us_d      = us_q;
    tmo_d     = tmo_q;
    sub_d     = sub_q;
    cm_d      = cm_q;
    sub_n     = sub_q;
    cm_n      = cm_q;
    done      = 1'b0;
    done_to   = 1'b0;
    result_cm = '0;
    unique case (state_q)
      StIdle: begin
        if (|en_mask) begin
          state_d = StTrig;
          ch_d    = next_ch;
          us_d    = '0;
        end
      end
      StTrig: begin
        tmo_d = '0;
        if (tick) begin
          if (us_q == TRIG_US - 1) state_d = StWaitRise;
          else                     us_d    = us_q + 32'd1;
        end
      end
      StWaitRise: begin
        if (tick) tmo_d = tmo_q + 32'd1;
        if (rise[ch_q]) begin
          state_d = StMeasure;
          sub_d   = '0;
          cm_d    = '0;
        end else if (tmo_exp) begin
          done    = 1'b1;
          done_to = 1'b1;
        end
      end
      StMeasure: begin
        if (tick) begin
          tmo_d = tmo_q + 32'd1;
          if (sub_q == SubLast) begin
            sub_n = '0;
            if (cm_q != DistMax) cm_n = cm_q + DistOne;
          end else begin
            sub_n = sub_q + 6'd1;
          end
        end
        sub_d = sub_n;
        cm_d  = cm_n;
        // The fall cycle's own tick counts, so an echo of k*58 us reads exactly k cm.
        if (fall[ch_q]) begin
          done      = 1'b1;
          result_cm = cm_n;
        end else if (tmo_exp) begin
          done    = 1'b1;
          done_to = 1'b1;
        end
      end
      StGap: begin
        if (tick) begin
          if (us_q == GAP_US - 1) state_d = StIdle;
          else                    us_d    = us_q + 32'd1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (done) begin
      state_d = StGap;
      us_d    = '0;
      ptr_d   = (ch_q == LastCh) ? '0 : ch_q + CH_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      state_q <= StIdle;
      ch_q    <= '0;
      ptr_q   <= '0;
      us_q    <= '0;
      tmo_q   <= '0;
      sub_q   <= '0;
      cm_q    <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      ptr_q   <= ptr_d;
      us_q    <= us_d;
      tmo_q   <= tmo_d;
      sub_q   <= sub_d;
      cm_q    <= cm_d;
    end
  end

  // Signed difference is one bit wider than the distance, so the step never overflows.
  always_comb begin
    cur_avg = avg_q[ch_q];
    diff    = $signed({1'b0, result_cm}) - $signed({1'b0, cur_avg});
    avg_new = first_q[ch_q] ? result_cm
                            : DIST_W'($signed({1'b0, cur_avg}) + (diff >>> AVG_SHIFT));
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      meas_valid_q <= 1'b0;
      meas_ch_q    <= '0;
      raw_q        <= '0;
      timeout_q    <= '0;
      near_q       <= '0;
      avg_q        <= '0;
      first_q      <= '1;
    end else begin
      meas_valid_q <= done;
      if (done) begin
        meas_ch_q <= ch_q;
        raw_q     <= done_to ? '0 : result_cm;
        if (done_to) begin
          timeout_q[ch_q] <= 1'b1;
        end else begin
          timeout_q[ch_q] <= 1'b0;
          avg_q[ch_q]     <= avg_new;
          first_q[ch_q]   <= 1'b0;
          near_q[ch_q]    <= (avg_new < NearCm);
        end
      end
    end
  end

  always_comb begin
    trig = '0;
    if (state_q == StTrig) trig[ch_q] = 1'b1;
  end

  assign dist_flat  = avg_q;
  assign raw_dist   = raw_q;
  assign meas_valid = meas_valid_q;
  assign meas_ch    = meas_ch_q;
  assign timeout    = timeout_q;
  assign near       = near_q;

endmodule
